// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: three valid/ready writeback sources plus the
// register-file write controls and mux selects.
interface wb_port_arbiter_if #(parameter int AW = 5);
    logic          wb_stall;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic          link_valid;
    logic [AW-1:0] link_addr;
    logic          link_ready;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic          alu_ready;
    logic          sel_link;
    logic          sel_mem;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic          starve_flag;

    modport slave (
        input  wb_stall, mem_valid, mem_addr, link_valid, link_addr, alu_valid, alu_addr,
        output mem_ready, link_ready, alu_ready, sel_link, sel_mem, rf_we, rf_waddr, starve_flag
    );

    modport master (
        output wb_stall, mem_valid, mem_addr, link_valid, link_addr, alu_valid, alu_addr,
        input  mem_ready, link_ready, alu_ready, sel_link, sel_mem, rf_we, rf_waddr, starve_flag
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter for MEM, LINK and ALU writeback sources.
// Optional WB_ARB_RR_EN replaces fixed MEM > LINK > ALU priority with round-robin.
module wb_port_arbiter #(
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int            CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_LINK = 2'd1,
        SRC_ALU  = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    logic [CW-1:0] mem_cnt, link_cnt, alu_cnt;
    logic [2:0]    valid_vec, boost_vec, cand_vec;
    src_e          winner, start_ptr;
    logic [AW-1:0] win_addr;
    logic          sel_link_q, sel_mem_q, rf_we_q;
    logic [AW-1:0] rf_waddr_q;

    // First set bit of v scanning MEM->LINK->ALU cyclically from start.
    function automatic src_e pick(input logic [2:0] v, input src_e start);
        int k;
        pick = SRC_NONE;
        for (int i = 0; i < 3; i++) begin
            k = (int'(start) + i) % 3;
            if (pick == SRC_NONE && v[k]) pick = src_e'(2'(k));
        end
    endfunction

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                               input logic valid, input logic granted);
        if (!valid || granted)   next_cnt = '0;
        else if (cnt != CNT_MAX) next_cnt = cnt + 1'b1;
        else                     next_cnt = cnt;
    endfunction

`ifdef WB_ARB_RR_EN
    src_e rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SRC_MEM;
        end else begin
            case (winner)
                SRC_MEM:  rr_ptr <= SRC_LINK;
                SRC_LINK: rr_ptr <= SRC_ALU;
                SRC_ALU:  rr_ptr <= SRC_MEM;
                default:  rr_ptr <= rr_ptr;
            endcase
        end
    end

    assign start_ptr = rr_ptr;
`else
    assign start_ptr = SRC_MEM;
`endif

    // Starved requesters mask out everyone else; ordering among them is the normal one.
    always_comb begin
        valid_vec = {bus.alu_valid, bus.link_valid, bus.mem_valid};
        boost_vec = valid_vec & {alu_cnt == CNT_MAX, link_cnt == CNT_MAX, mem_cnt == CNT_MAX};
        cand_vec  = (|boost_vec) ? boost_vec : valid_vec;
        winner    = SRC_NONE;
        if (!bus.wb_stall) winner = pick(cand_vec, start_ptr);
        case (winner)
            SRC_MEM:  win_addr = bus.mem_addr;
            SRC_LINK: win_addr = bus.link_addr;
            SRC_ALU:  win_addr = bus.alu_addr;
            default:  win_addr = '0;
        endcase
    end

    assign bus.mem_ready   = (winner == SRC_MEM);
    assign bus.link_ready  = (winner == SRC_LINK);
    assign bus.alu_ready   = (winner == SRC_ALU);
    assign bus.starve_flag = !bus.wb_stall && (|boost_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt  <= '0;
            link_cnt <= '0;
            alu_cnt  <= '0;
        end else if (!bus.wb_stall) begin
            mem_cnt  <= next_cnt(mem_cnt,  bus.mem_valid,  winner == SRC_MEM);
            link_cnt <= next_cnt(link_cnt, bus.link_valid, winner == SRC_LINK);
            alu_cnt  <= next_cnt(alu_cnt,  bus.alu_valid,  winner == SRC_ALU);
        end
    end

    // Writes to $zero still move the selects and address, but never enable the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_link_q <= 1'b0;
            sel_mem_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
        end else if (winner != SRC_NONE) begin
            sel_link_q <= (winner == SRC_LINK);
            sel_mem_q  <= (winner == SRC_MEM);
            rf_we_q    <= (win_addr != '0);
            rf_waddr_q <= win_addr;
        end else begin
            rf_we_q    <= 1'b0;
        end
    end

    assign bus.sel_link = sel_link_q;
    assign bus.sel_mem  = sel_mem_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; follows the WB_ARB_RR_EN
// build option to pick fixed-priority or round-robin expectations.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;

    wb_port_arbiter_if #(.AW(5)) bus ();

    wb_port_arbiter #(.AW(5), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic stall,
                                 input logic mv, input logic [4:0] ma,
                                 input logic lv, input logic [4:0] la,
                                 input logic av, input logic [4:0] aa);
        bus.wb_stall   = stall;
        bus.mem_valid  = mv;
        bus.mem_addr   = ma;
        bus.link_valid = lv;
        bus.link_addr  = la;
        bus.alu_valid  = av;
        bus.alu_addr   = aa;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        #12;
        rst_n = 1'b1;
        tick();

        checkOutput("reset_rf_we",      32'(bus.rf_we),      0);
        checkOutput("reset_rf_waddr",   32'(bus.rf_waddr),   0);
        checkOutput("reset_sel_link",   32'(bus.sel_link),   0);
        checkOutput("reset_sel_mem",    32'(bus.sel_mem),    0);
        checkOutput("reset_mem_ready",  32'(bus.mem_ready),  0);
        checkOutput("reset_link_ready", 32'(bus.link_ready), 0);
        checkOutput("reset_alu_ready",  32'(bus.alu_ready),  0);

        // All three valid: MEM wins on a fresh reset in either priority mode.
        applyStimulus(0, 1, 5'd8, 1, 5'd31, 1, 5'd3);
        checkOutput("all3_mem_ready",  32'(bus.mem_ready),  1);
        checkOutput("all3_link_ready", 32'(bus.link_ready), 0);
        checkOutput("all3_alu_ready",  32'(bus.alu_ready),  0);
        tick();
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        checkOutput("all3_rf_we",    32'(bus.rf_we),    1);
        checkOutput("all3_rf_waddr", 32'(bus.rf_waddr), 8);
        checkOutput("all3_sel_mem",  32'(bus.sel_mem),  1);
        checkOutput("all3_sel_link", 32'(bus.sel_link), 0);
        tick();
        checkOutput("idle_rf_we",        32'(bus.rf_we),   0);
        checkOutput("idle_sel_mem_hold", 32'(bus.sel_mem), 1);

        // Link write to $zero is accepted but must not enable the write.
        applyStimulus(0, 0, 5'd0, 1, 5'd0, 0, 5'd0);
        checkOutput("zero_link_ready", 32'(bus.link_ready), 1);
        tick();
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        checkOutput("zero_rf_we",    32'(bus.rf_we),    0);
        checkOutput("zero_sel_link", 32'(bus.sel_link), 1);
        checkOutput("zero_rf_waddr", 32'(bus.rf_waddr), 0);

        applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd7);
        checkOutput("stall_alu_ready", 32'(bus.alu_ready), 0);
        tick();
        checkOutput("stall_rf_we",         32'(bus.rf_we),    0);
        checkOutput("stall_sel_link_hold", 32'(bus.sel_link), 1);
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 1, 5'd7);
        checkOutput("unstall_alu_ready", 32'(bus.alu_ready), 1);
        tick();
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        checkOutput("unstall_rf_we",    32'(bus.rf_we),    1);
        checkOutput("unstall_rf_waddr", 32'(bus.rf_waddr), 7);
        checkOutput("unstall_sel_link", 32'(bus.sel_link), 0);
        checkOutput("unstall_sel_mem",  32'(bus.sel_mem),  0);

`ifdef WB_ARB_RR_EN
        pulseReset();
        applyStimulus(0, 1, 5'd8, 1, 5'd31, 1, 5'd3);
        checkOutput("rr0_mem_ready",  32'(bus.mem_ready),  1);
        tick();
        checkOutput("rr1_link_ready", 32'(bus.link_ready), 1);
        checkOutput("rr1_rf_waddr",   32'(bus.rf_waddr),   8);
        tick();
        checkOutput("rr2_alu_ready",  32'(bus.alu_ready),  1);
        checkOutput("rr2_rf_waddr",   32'(bus.rf_waddr),   31);
        tick();
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        checkOutput("rr3_rf_waddr",   32'(bus.rf_waddr),   3);
`else
        // ALU loses four cycles to MEM, then gets boosted past it.
        pulseReset();
        applyStimulus(0, 1, 5'd5, 0, 5'd0, 1, 5'd3);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("starve_c%0d_mem_ready", c), 32'(bus.mem_ready), 1);
            checkOutput($sformatf("starve_c%0d_alu_ready", c), 32'(bus.alu_ready), 0);
            checkOutput($sformatf("starve_c%0d_flag", c), 32'(bus.starve_flag), 0);
            tick();
        end
        checkOutput("starve_c4_alu_ready", 32'(bus.alu_ready),   1);
        checkOutput("starve_c4_mem_ready", 32'(bus.mem_ready),   0);
        checkOutput("starve_c4_flag",      32'(bus.starve_flag), 1);
        checkOutput("starve_c4_waddr",     32'(bus.rf_waddr),    5);
        tick();
        checkOutput("starve_c5_rf_waddr", 32'(bus.rf_waddr), 3);
        checkOutput("starve_c5_sel_mem",  32'(bus.sel_mem),  0);
        checkOutput("starve_c5_rf_we",    32'(bus.rf_we),    1);
        checkOutput("starve_c5_flag",     32'(bus.starve_flag), 0);

        // Asynchronous reset mid-stream clears outputs without waiting for an edge.
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rf_we",    32'(bus.rf_we),    0);
        checkOutput("async_rst_rf_waddr", 32'(bus.rf_waddr), 0);
        checkOutput("async_rst_sel_mem",  32'(bus.sel_mem),  0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
